// File: rtl/seq_mult_param.sv
// Sequential shift-and-add multiplier: WIDTH-bit signed/unsigned operands, one multiplier bit per cycle.
// Define MULT_ACC_EN to add the acc port, which accumulates each product into the previous result.
module seq_mult_param #(
    parameter int WIDTH = 8          // legal range 2..32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MULT_ACC_EN
    input  logic                 acc,
`endif
    output logic [2*WIDTH-1:0]   c,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   psum;
    logic [PW-1:0]   psum_n;
    logic [PW-1:0]   ash;       // multiplicand, pre-shifted to the current iteration's weight
    logic [WIDTH-1:0] bsh;      // multiplier, bit 0 is the bit under examination
    logic            sgn_q;
    logic            last;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   a_ext;
`ifdef MULT_ACC_EN
    logic            acc_q;
`endif

    assign last  = (cnt == CW'(WIDTH - 1));
    assign a_ext = {{WIDTH{sgn & a[WIDTH-1]}}, a};

    // The signed MSB of the multiplier carries negative weight, so the final step subtracts.
    always_comb begin
        addend = '0;
        psum_n = psum;
        if (bsh[0])
            addend = ash;
        if (sgn_q && last)
            psum_n = psum - addend;
        else
            psum_n = psum + addend;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            psum  <= '0;
            ash   <= '0;
            bsh   <= '0;
            sgn_q <= 1'b0;
            c     <= '0;
`ifdef MULT_ACC_EN
            acc_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        ash   <= a_ext;
                        bsh   <= b;
                        sgn_q <= sgn;
                        psum  <= '0;
                        cnt   <= '0;
`ifdef MULT_ACC_EN
                        acc_q <= acc;
`endif
                    end
                end
                RUN: begin
                    psum <= psum_n;
                    ash  <= ash << 1;
                    bsh  <= bsh >> 1;
                    cnt  <= cnt + 1'b1;
                    // Result register only changes here, so c never exposes partial sums.
                    if (last) begin
`ifdef MULT_ACC_EN
                        c <= acc_q ? (c + psum_n) : psum_n;
`else
                        c <= psum_n;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) && !rst;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: directed corner cases plus random operands vs. an arithmetic model.
module tb_seq_mult_param;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, sgn;
    logic [W-1:0]  a, b;
    bit            acc;
    logic [2*W-1:0] c;
    logic          done, busy;

    logic          start4, sgn4;
    logic [3:0]    a4, b4;
    bit            acc4;
    logic [7:0]    c4;
    logic          done4, busy4;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] model_c;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
`ifdef MULT_ACC_EN
        .acc(acc),
`endif
        .c(c), .done(done), .busy(busy)
    );

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
`ifdef MULT_ACC_EN
        .acc(acc4),
`endif
        .c(c4), .done(done4), .busy(busy4)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // True mathematical product reduced modulo 2^(2W).
    function automatic logic [2*W-1:0] ref_prod(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint px, py, p;
        px = s ? longint'($signed(x)) : longint'({56'b0, x});
        py = s ? longint'($signed(y)) : longint'({56'b0, y});
        p  = px * py;
        return p[2*W-1:0];
    endfunction

    // One full operation; dup re-pulses start (different operands) two cycles in.
    task automatic run_op(input string tag, input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit ac, input bit dup);
        int lat, nbusy, ndone;
        logic [2*W-1:0] p;
        bit ac_eff;
`ifdef MULT_ACC_EN
        ac_eff = ac;
`else
        ac_eff = 1'b0;
`endif
        p = ref_prod(s, x, y);
        model_c = ac_eff ? model_c + p : p;
        start = 1'b1; sgn = s; a = x; b = y; acc = ac;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); sgn = ~s;
        nbusy = int'(busy); ndone = 0; lat = -1;
        for (int k = 1; k <= W + 3; k++) begin
            if (dup && k == 2) begin
                start = 1'b1; a = ~x; b = ~y;
            end
            @(posedge clk); #1;
            start = 1'b0;
            nbusy += int'(busy);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    chk({tag, ".c_at_done"}, longint'(c), longint'(model_c));
                end
            end
        end
        chk({tag, ".latency"}, lat, W);
        chk({tag, ".done_pulses"}, ndone, 1);
        chk({tag, ".busy_cycles"}, nbusy, W + 1);
        chk({tag, ".c_hold"}, longint'(c), longint'(model_c));
    endtask

    initial begin
        int lat, ndone;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0; acc = 1'b0;
        start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0; acc4 = 1'b0;
        model_c = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.c", longint'(c), 0);
        chk("reset.busy", longint'(busy), 0);
        chk("reset.done", longint'(done), 0);
        rst = 1'b1;
        #1;
        chk("reset.done_during_rst", longint'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // WIDTH=4 signed: -7 * 2 = -14
        start4 = 1'b1; sgn4 = 1'b1; a4 = 4'b1001; b4 = 4'b0010;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (done4 && lat < 0) lat = k;
        end
        chk("w4.latency", lat, 4);
        chk("w4.c", longint'(c4), 8'hF2);

        run_op("ff_u", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        chk("ff_u.const", longint'(c), 16'hFE01);
        run_op("ff_s", 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        chk("ff_s.const", longint'(c), 16'h0001);
        run_op("min_min", 1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
        chk("min_min.const", longint'(c), 16'h4000);
        run_op("min_one", 1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
        chk("min_one.const", longint'(c), 16'hFF80);
        run_op("dup_start", 1'b0, 8'd13, 8'd11, 1'b0, 1'b1);
        chk("dup_start.const", longint'(c), 16'd143);

        // Reset at the edge performing iteration 3 aborts the run.
        start = 1'b1; sgn = 1'b0; a = 8'd9; b = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_c = '0;
        chk("abort.c", longint'(c), 0);
        chk("abort.busy", longint'(busy), 0);
        chk("abort.done", longint'(done), 0);
        ndone = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            ndone += int'(done);
        end
        chk("abort.no_done", ndone, 0);
        run_op("after_abort", 1'b1, 8'hF9, 8'h05, 1'b0, 1'b0);
        chk("after_abort.const", longint'(c), 16'hFFDD);

`ifdef MULT_ACC_EN
        run_op("acc0", 1'b0, 8'd3, 8'd4, 1'b0, 1'b0);
        chk("acc0.const", longint'(c), 16'd12);
        run_op("acc1", 1'b0, 8'd5, 8'd6, 1'b1, 1'b0);
        chk("acc1.const", longint'(c), 16'd42);
        run_op("wrap0", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op("wrap1", 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        chk("wrap1.const", longint'(c), 16'hFC02);
`endif

        for (int i = 0; i < 24; i++)
            run_op($sformatf("rnd%0d", i), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
